subbytes_sched: RTL and testbench
=================================

Name: subbytes_sched

Overview:
- Time-shares one 32-bit, 4-S-box SubBytes datapath between two requesters: the key-schedule SubWord path (32-bit) and the cipher-round state path (128-bit).
- Arbitrates round-robin between the two, then sequences a 128-bit state through the 32-bit S-box in four word passes.
- The S-box stays combinational and external. This block drives its input and samples its output.

Parameters:
- KS_FIRST, 1, round-robin pointer after reset. 1 = key schedule wins the first tie; 0 = state path wins.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ks_valid  in  1  key-schedule request valid
- ks_ready  out  1  key-schedule request accepted this cycle (combinational)
- ks_din  in  32  word for SubWord
- ks_out_valid  out  1  one-cycle pulse, ks_dout is new
- ks_dout  out  32  SubWord result, held until next KS completion
- st_valid  in  1  state request valid
- st_ready  out  1  state request accepted this cycle (combinational)
- st_din  in  128  state; word3 = [127:96] … word0 = [31:0]
- st_out_valid  out  1  one-cycle pulse, st_dout is new
- st_dout  out  128  SubBytes result, held until next ST completion
- sbox_x  out  32  to shared S-box input
- sbox_y  in  32  from shared S-box output (combinational function of sbox_x)
- busy  out  1  high in KS or ST state

Behaviour:
- Reset (async, rst=1): state=IDLE; wcnt=0; rr pointer=KS_FIRST. Reset values: ks_out_valid=0, st_out_valid=0, ks_dout=0, st_dout=0, busy=0. sbox_x follows state, so it reads 0.
- States: IDLE, KS, ST.
- Handshake: a transfer occurs on the rising edge where valid&&ready. A requester holds valid and data stable until accepted. The ready outputs are nonzero only in IDLE.
- Arbitration in IDLE:
  - Only ks_valid high: ks_ready=1.
  - Only st_valid high: st_ready=1.
  - Both high: grant the requester the rr pointer favours. Exactly one ready is high.
  - On each accept, the pointer flips to favour the other requester.
- IDLE -> KS on KS accept (edge E0): ks_din registered.
  - KS cycle: sbox_x = registered word.
  - At E1: ks_dout <= sbox_y; ks_out_valid=1 for the cycle E1–E2; state -> IDLE.
- IDLE -> ST on ST accept (E0): st_din registered; wcnt=0.
  - ST cycle k (k=0..3): sbox_x = word (3-k), i.e. MSW first.
  - At each edge, sbox_y is written into word (3-k) of an internal accumulator.
  - At E4 (wcnt=3): st_dout <= full accumulator, including the last word; st_out_valid=1 for the cycle E4–E5; state -> IDLE.
- Latency: KS = 1 edge after accept; ST = 4 edges after accept.
- Back-to-back: in the cycle an out_valid is high, the FSM is in IDLE and can accept a new request. Maximum rate is one KS per 2 cycles or one ST per 5 cycles.
- sbox_x = 0 in IDLE.
- st_dout updates only at completion, never with partial words. Both output holding registers keep their value across the other path's operations.
- No output backpressure: out_valid pulses exactly one cycle.
- Valid dropped while not accepted: no effect and no grant. A pointer change occurs only on an accept.
- rst asserted mid-KS or mid-ST: the operation is aborted immediately. No out_valid pulse; outputs and pointer return to reset values. The requester must re-issue.
- A request arriving while busy is not accepted until IDLE. It then competes under round-robin.

Test Plan:
- After reset, ks_valid=1 with ks_din=32'h00010253 -> ks_ready=1 in IDLE; one edge later ks_out_valid=1, ks_dout=32'h637C77ED; busy high for exactly 1 cycle.
- st_valid=1, st_din=128'h00112233445566778899AABBCCDDEEFF -> sbox_x sequence 00112233, 44556677, 8899AABB, CCDDEEFF; 4 edges later st_out_valid=1 with st_dout=128'h638293C31BFC33F5C4EEACEA4BC12816; st_dout unchanged before that.
- Both valid continuously, KS_FIRST=1 -> grant order KS, ST, KS, ST; each result correct; ks_dout keeps its value while ST runs.
- ks_valid asserted during ST busy (ks_din=32'hFFFFFFFF) -> ks_ready=0 until the IDLE cycle of the st_out_valid pulse. That same cycle it is accepted, and ks_dout=32'h16161616 one edge later.
- rst pulsed after the 2nd ST word -> no st_out_valid, st_dout=0, busy=0, sbox_x=0. A re-issued request then completes normally with the pointer at KS_FIRST.
- KS_FIRST=0 with simultaneous first requests -> st_ready=1 and ks_ready=0 on the first cycle.

Source files
------------

// File: rtl/subbytes_sched.sv
// Round-robin scheduler sharing one external 32-bit S-box between the key-schedule
// SubWord path and the 128-bit cipher-state SubBytes path (state processed MSW first).
module subbytes_sched #(
  parameter bit KS_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ks_valid,
  output logic         ks_ready,
  input  logic [31:0]  ks_din,
  output logic         ks_out_valid,
  output logic [31:0]  ks_dout,
  input  logic         st_valid,
  output logic         st_ready,
  input  logic [127:0] st_din,
  output logic         st_out_valid,
  output logic [127:0] st_dout,
  output logic [31:0]  sbox_x,
  input  logic [31:0]  sbox_y,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, KS, ST} state_e;

  state_e         state_q, state_d;
  logic [1:0]     wcnt_q, wcnt_d;
  logic           rr_q, rr_d;       // 1: key schedule wins the next tie
  logic [31:0]    ks_word_q, ks_word_d;
  logic [127:0]   st_word_q, st_word_d;
  logic [127:0]   acc_q, acc_d;
  logic [31:0]    ks_dout_q, ks_dout_d;
  logic [127:0]   st_dout_q, st_dout_d;
  logic           ks_ov_q, ks_ov_d;
  logic           st_ov_q, st_ov_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      rr_q      <= KS_FIRST;
      ks_word_q <= '0;
      st_word_q <= '0;
      acc_q     <= '0;
      ks_dout_q <= '0;
      st_dout_q <= '0;
      ks_ov_q   <= 1'b0;
      st_ov_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      rr_q      <= rr_d;
      ks_word_q <= ks_word_d;
      st_word_q <= st_word_d;
      acc_q     <= acc_d;
      ks_dout_q <= ks_dout_d;
      st_dout_q <= st_dout_d;
      ks_ov_q   <= ks_ov_d;
      st_ov_q   <= st_ov_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    rr_d      = rr_q;
    ks_word_d = ks_word_q;
    st_word_d = st_word_q;
    acc_d     = acc_q;
    ks_dout_d = ks_dout_q;
    st_dout_d = st_dout_q;
    ks_ov_d   = 1'b0;
    st_ov_d   = 1'b0;
    ks_ready  = 1'b0;
    st_ready  = 1'b0;
    sbox_x    = '0;

    case (state_q)
      IDLE: begin
        ks_ready = ks_valid && (!st_valid || rr_q);
        st_ready = st_valid && (!ks_valid || !rr_q);
        if (ks_ready) begin
          ks_word_d = ks_din;
          rr_d      = 1'b0;
          state_d   = KS;
        end else if (st_ready) begin
          st_word_d = st_din;
          wcnt_d    = '0;
          rr_d      = 1'b1;
          state_d   = ST;
        end
      end
      KS: begin
        sbox_x    = ks_word_q;
        ks_dout_d = sbox_y;
        ks_ov_d   = 1'b1;
        state_d   = IDLE;
      end
      ST: begin
        case (wcnt_q)
          2'd0: begin sbox_x = st_word_q[127:96]; acc_d[127:96] = sbox_y; end
          2'd1: begin sbox_x = st_word_q[95:64];  acc_d[95:64]  = sbox_y; end
          2'd2: begin sbox_x = st_word_q[63:32];  acc_d[63:32]  = sbox_y; end
          default: begin sbox_x = st_word_q[31:0]; acc_d[31:0] = sbox_y; end
        endcase
        // Final word is merged via acc_d so st_dout never exposes a partial result.
        if (wcnt_q == 2'd3) begin
          st_dout_d = acc_d;
          st_ov_d   = 1'b1;
          wcnt_d    = '0;
          state_d   = IDLE;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ks_out_valid = ks_ov_q;
  assign st_out_valid = st_ov_q;
  assign ks_dout      = ks_dout_q;
  assign st_dout      = st_dout_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_subbytes_sched.sv
// Directed bench for subbytes_sched: two instances (KS_FIRST=1 and 0) each driving an AES S-box model.
module tb_subbytes_sched;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  function automatic logic [31:0] subword(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  localparam logic [127:0] ST_A   = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] ST_A_S = 128'h638293C31BFC33F5C4EEACEA4BC12816;
  localparam logic [127:0] ST_B   = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] ST_B_S = 128'h637C777BF26B6FC53001672BFED7AB76;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         ks_valid = 1'b0, st_valid = 1'b0;
  logic [31:0]  ks_din = '0;
  logic [127:0] st_din = '0;
  logic         ks_ready, st_ready, ks_out_valid, st_out_valid, busy;
  logic [31:0]  ks_dout, sbox_x, sbox_y;
  logic [127:0] st_dout;

  logic         ks_valid0 = 1'b0, st_valid0 = 1'b0;
  logic         ks_ready0, st_ready0, ks_out_valid0, st_out_valid0, busy0;
  logic [31:0]  ks_dout0, sbox_x0, sbox_y0;
  logic [127:0] st_dout0;

  assign sbox_y  = subword(sbox_x);
  assign sbox_y0 = subword(sbox_x0);

  subbytes_sched #(.KS_FIRST(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_din(ks_din),
    .ks_out_valid(ks_out_valid), .ks_dout(ks_dout),
    .st_valid(st_valid), .st_ready(st_ready), .st_din(st_din),
    .st_out_valid(st_out_valid), .st_dout(st_dout),
    .sbox_x(sbox_x), .sbox_y(sbox_y), .busy(busy)
  );

  subbytes_sched #(.KS_FIRST(1'b0)) u_dut0 (
    .clk(clk), .rst(rst),
    .ks_valid(ks_valid0), .ks_ready(ks_ready0), .ks_din(32'h00010253),
    .ks_out_valid(ks_out_valid0), .ks_dout(ks_dout0),
    .st_valid(st_valid0), .st_ready(st_ready0), .st_din(ST_A),
    .st_out_valid(st_out_valid0), .st_dout(st_dout0),
    .sbox_x(sbox_x0), .sbox_y(sbox_y0), .busy(busy0)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] st_words [4];

  initial begin
    // Reset values
    #2;
    check("rst_ks_ov", ks_out_valid, 0);
    check("rst_st_ov", st_out_valid, 0);
    check("rst_ks_dout", ks_dout, 0);
    check("rst_st_dout", st_dout, 0);
    check("rst_busy", busy, 0);
    check("rst_sbox_x", sbox_x, 0);
    step(); step();
    rst = 1'b0;

    // KS_FIRST=0 instance: simultaneous first requests go to the state path
    ks_valid0 = 1'b1; st_valid0 = 1'b1;
    #1;
    check("ksf0_st_ready", st_ready0, 1);
    check("ksf0_ks_ready", ks_ready0, 0);
    step();
    ks_valid0 = 1'b0; st_valid0 = 1'b0;
    check("ksf0_busy", busy0, 1);
    check("ksf0_sbox_x", sbox_x0, ST_A[127:96]);

    // Single KS request
    check("idle_ks_ready", ks_ready, 0);
    ks_valid = 1'b1; ks_din = 32'h00010253;
    #1;
    check("t1_ks_ready", ks_ready, 1);
    check("t1_st_ready", st_ready, 0);
    step();
    ks_valid = 1'b0;
    check("t1_busy", busy, 1);
    check("t1_sbox_x", sbox_x, 32'h00010253);
    check("t1_ks_ov_early", ks_out_valid, 0);
    step();
    check("t1_ks_ov", ks_out_valid, 1);
    check("t1_ks_dout", ks_dout, 32'h637C77ED);
    check("t1_busy_done", busy, 0);
    check("t1_sbox_idle", sbox_x, 0);
    step();
    check("t1_ks_ov_pulse", ks_out_valid, 0);
    check("t1_ks_dout_hold", ks_dout, 32'h637C77ED);

    // Single ST request, MSW first
    st_words = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    st_valid = 1'b1; st_din = ST_A;
    #1;
    check("t2_st_ready", st_ready, 1);
    step();
    st_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t2_sbox_x%0d", k), sbox_x, st_words[k]);
      check($sformatf("t2_st_dout_hold%0d", k), st_dout, 0);
      check($sformatf("t2_busy%0d", k), busy, 1);
      step();
    end
    check("t2_st_ov", st_out_valid, 1);
    check("t2_st_dout", st_dout, ST_A_S);
    check("t2_busy_done", busy, 0);
    step();
    check("t2_st_ov_pulse", st_out_valid, 0);

    // Both valid continuously: KS, ST, KS
    ks_valid = 1'b1; ks_din = 32'h00000000;
    st_valid = 1'b1; st_din = ST_B;
    #1;
    check("t3_ks_ready", ks_ready, 1);
    check("t3_st_ready", st_ready, 0);
    step();
    ks_din = 32'h53535353;
    check("t3_busy_ks_ready", ks_ready, 0);
    check("t3_busy_st_ready", st_ready, 0);
    step();
    check("t3_ks_ov", ks_out_valid, 1);
    check("t3_ks_dout", ks_dout, 32'h63636363);
    check("t3_st_ready2", st_ready, 1);
    check("t3_ks_ready2", ks_ready, 0);
    step();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t3_ks_hold%0d", k), ks_dout, 32'h63636363);
      check($sformatf("t3_st_ov_early%0d", k), st_out_valid, 0);
      step();
    end
    check("t3_st_ov", st_out_valid, 1);
    check("t3_st_dout", st_dout, ST_B_S);
    check("t3_ks_ready3", ks_ready, 1);
    step();
    ks_valid = 1'b0; st_valid = 1'b0;
    step();
    check("t3_ks_ov2", ks_out_valid, 1);
    check("t3_ks_dout2", ks_dout, 32'hEDEDEDED);
    check("t3_st_dout_hold", st_dout, ST_B_S);

    // KS request arriving while ST busy
    st_valid = 1'b1; st_din = {4{32'h53535353}};
    #1;
    check("t4_st_ready", st_ready, 1);
    step();
    st_valid = 1'b0;
    ks_valid = 1'b1; ks_din = 32'hFFFFFFFF;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("t4_ks_blocked%0d", k), ks_ready, 0);
      step();
    end
    check("t4_st_ov", st_out_valid, 1);
    check("t4_st_dout", st_dout, {4{32'hEDEDEDED}});
    check("t4_ks_ready", ks_ready, 1);
    step();
    ks_valid = 1'b0;
    step();
    check("t4_ks_ov", ks_out_valid, 1);
    check("t4_ks_dout", ks_dout, 32'h16161616);

    // Reset during ST after two words, then re-issue
    st_valid = 1'b1; st_din = ST_A;
    #1;
    check("t5_st_ready", st_ready, 1);
    step();
    st_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_sbox_x", sbox_x, 0);
    check("t5_rst_st_ov", st_out_valid, 0);
    check("t5_rst_st_dout", st_dout, 0);
    check("t5_rst_ks_dout", ks_dout, 0);
    step();
    rst = 1'b0;
    step();
    check("t5_no_st_ov", st_out_valid, 0);
    check("t5_idle", busy, 0);
    ks_valid = 1'b1; ks_din = 32'h00010253;
    st_valid = 1'b1; st_din = ST_A;
    #1;
    check("t5_ptr_ks_ready", ks_ready, 1);
    check("t5_ptr_st_ready", st_ready, 0);
    step();
    ks_valid = 1'b0;
    step();
    check("t5_ks_ov", ks_out_valid, 1);
    check("t5_ks_dout", ks_dout, 32'h637C77ED);
    check("t5_st_ready2", st_ready, 1);
    step();
    st_valid = 1'b0;
    step(); step(); step();
    check("t5_st_dout_partial", st_dout, 0);
    step();
    check("t5_st_ov", st_out_valid, 1);
    check("t5_st_dout", st_dout, ST_A_S);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
